// File: rtl/cpu_run_ctrl.sv
// Run/halt/step sequencer and program loader for the 4-bit cpu core.
// Optional breakpoint logic is compiled in when TW4_BREAKPOINT_EN is defined.
module cpu_run_ctrl #(
  parameter int ADDR_W  = 4,
  parameter int DATA_W  = 8,
  parameter int CYCLE_W = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_op,
  input  logic [ADDR_W-1:0]  cmd_addr,
  input  logic [DATA_W-1:0]  cmd_data,
  output logic               cmd_err,
  input  logic [ADDR_W-1:0]  fetch_addr,
  output logic               cpu_en,
  output logic               mem_we,
  output logic [ADDR_W-1:0]  mem_waddr,
  output logic [DATA_W-1:0]  mem_wdata,
  input  logic               bp_en,
  input  logic [ADDR_W-1:0]  bp_addr,
  output logic               bp_hit,
  output logic [1:0]         state,
  output logic [CYCLE_W-1:0] cycle_cnt
);

  typedef enum logic [1:0] {
    S_HALT = 2'b00,
    S_RUN  = 2'b01,
    S_STEP = 2'b10,
    S_LOAD = 2'b11
  } state_t;

  localparam logic [1:0] OP_RUN  = 2'b00;
  localparam logic [1:0] OP_HALT = 2'b01;
  localparam logic [1:0] OP_STEP = 2'b10;
  localparam logic [1:0] OP_LOAD = 2'b11;

  state_t              state_reg, state_next;
  logic                err_reg, err_next;
  logic [ADDR_W-1:0]   waddr_reg, waddr_next;
  logic [DATA_W-1:0]   wdata_reg, wdata_next;
  logic                bp_hit_reg, bp_hit_next;
  logic                first_reg, first_next;
  logic [CYCLE_W-1:0]  cnt_reg;
  logic                accept;
  logic                bp_hit_now;

`ifdef TW4_BREAKPOINT_EN
  // The first RUN cycle is exempt so execution can resume from the breakpoint address.
  assign bp_hit_now = (state_reg == S_RUN) && bp_en && (fetch_addr == bp_addr) && !first_reg;
`else
  logic unused_bp;
  assign unused_bp  = ^{bp_en, bp_addr, fetch_addr, first_reg};
  assign bp_hit_now = 1'b0;
`endif

  assign cmd_ready = !reset && ((state_reg == S_HALT) || (state_reg == S_RUN));
  assign accept    = cmd_valid && cmd_ready;
  assign cpu_en    = !reset && (((state_reg == S_RUN) && !bp_hit_now) || (state_reg == S_STEP));
  assign mem_we    = !reset && (state_reg == S_LOAD);
  assign cmd_err   = err_reg;
  assign mem_waddr = waddr_reg;
  assign mem_wdata = wdata_reg;
  assign bp_hit    = bp_hit_reg;
  assign state     = state_reg;
  assign cycle_cnt = cnt_reg;

  always_comb begin
    state_next  = state_reg;
    err_next    = 1'b0;
    waddr_next  = waddr_reg;
    wdata_next  = wdata_reg;
    bp_hit_next = bp_hit_reg;
    first_next  = 1'b0;
    case (state_reg)
      S_HALT: begin
        if (accept) begin
          case (cmd_op)
            OP_RUN: begin
              state_next = S_RUN;
              first_next = 1'b1;
            end
            OP_STEP: state_next = S_STEP;
            OP_LOAD: begin
              state_next = S_LOAD;
              waddr_next = cmd_addr;
              wdata_next = cmd_data;
            end
            default: state_next = S_HALT;
          endcase
        end
      end
      S_RUN: begin
        if (accept && (cmd_op == OP_HALT)) state_next = S_HALT;
        if (accept && ((cmd_op == OP_STEP) || (cmd_op == OP_LOAD))) err_next = 1'b1;
        if (bp_hit_now) state_next = S_HALT;
      end
      default: state_next = S_HALT;
    endcase
`ifdef TW4_BREAKPOINT_EN
    if (accept && ((cmd_op == OP_RUN) || (cmd_op == OP_STEP))) bp_hit_next = 1'b0;
    if (bp_hit_now) bp_hit_next = 1'b1;
`else
    bp_hit_next = 1'b0;
`endif
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg  <= S_HALT;
      err_reg    <= 1'b0;
      waddr_reg  <= '0;
      wdata_reg  <= '0;
      bp_hit_reg <= 1'b0;
      first_reg  <= 1'b0;
      cnt_reg    <= '0;
    end else begin
      state_reg  <= state_next;
      err_reg    <= err_next;
      waddr_reg  <= waddr_next;
      wdata_reg  <= wdata_next;
      bp_hit_reg <= bp_hit_next;
      first_reg  <= first_next;
      if (cpu_en && (cnt_reg != {CYCLE_W{1'b1}})) cnt_reg <= cnt_reg + 1'b1;
    end
  end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Bench for cpu_run_ctrl: directed scenarios with literal expectations plus a random
// phase, all cross-checked every cycle against a behavioural model.
module tb_cpu_run_ctrl;

`ifdef TW4_BREAKPOINT_EN
  localparam bit BP = 1'b1;
`else
  localparam bit BP = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic [1:0]  cmd_op = 2'd0;
  logic [3:0]  cmd_addr = 4'd0;
  logic [7:0]  cmd_data = 8'd0;
  logic [3:0]  fetch_addr;
  logic        bp_en = 1'b0;
  logic [3:0]  bp_addr = 4'd0;

  logic        cmd_ready, cmd_err, cpu_en, mem_we, bp_hit;
  logic [3:0]  mem_waddr;
  logic [7:0]  mem_wdata;
  logic [1:0]  state;
  logic [15:0] cycle_cnt;

  logic        cmd_ready4, cmd_err4, cpu_en4, mem_we4, bp_hit4;
  logic [3:0]  mem_waddr4;
  logic [7:0]  mem_wdata4;
  logic [1:0]  state4;
  logic [3:0]  cycle_cnt4;

  int n_checks = 0;
  int n_errors = 0;

  cpu_run_ctrl #(.ADDR_W(4), .DATA_W(8), .CYCLE_W(16)) dut (
    .clock(clock), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_err(cmd_err),
    .fetch_addr(fetch_addr), .cpu_en(cpu_en), .mem_we(mem_we), .mem_waddr(mem_waddr),
    .mem_wdata(mem_wdata), .bp_en(bp_en), .bp_addr(bp_addr), .bp_hit(bp_hit),
    .state(state), .cycle_cnt(cycle_cnt)
  );

  cpu_run_ctrl #(.ADDR_W(4), .DATA_W(8), .CYCLE_W(4)) dut4 (
    .clock(clock), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready4),
    .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_err(cmd_err4),
    .fetch_addr(fetch_addr), .cpu_en(cpu_en4), .mem_we(mem_we4), .mem_waddr(mem_waddr4),
    .mem_wdata(mem_wdata4), .bp_en(bp_en), .bp_addr(bp_addr), .bp_hit(bp_hit4),
    .state(state4), .cycle_cnt(cycle_cnt4)
  );

  always #5 clock = ~clock;

  // Stand-in core: fetch address advances with every committed instruction.
  always @(posedge clock) begin
    if (reset) fetch_addr <= 4'd0;
    else if (cpu_en) fetch_addr <= fetch_addr + 4'd1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: which activity is pending and what has been observed so far.
  bit        m_run = 0, m_step = 0, m_load = 0, m_first = 0, m_bp = 0, m_err = 0;
  bit [3:0]  m_waddr = 0;
  bit [7:0]  m_wdata = 0;
  int        m_cnt = 0;

  always @(negedge clock) begin
    bit e_ready, acc, hit, e_cpu, e_we;
    bit [1:0] e_state;
    e_ready = !reset && !m_step && !m_load;
    acc     = cmd_valid && e_ready;
    hit     = BP && m_run && bp_en && (fetch_addr == bp_addr) && !m_first;
    e_cpu   = !reset && ((m_run && !hit) || m_step);
    e_we    = !reset && m_load;
    e_state = m_load ? 2'd3 : m_step ? 2'd2 : m_run ? 2'd1 : 2'd0;
    check("cmd_ready", {31'd0, cmd_ready}, {31'd0, e_ready});
    check("cpu_en",    {31'd0, cpu_en},    {31'd0, e_cpu});
    check("mem_we",    {31'd0, mem_we},    {31'd0, e_we});
    check("mem_waddr", {28'd0, mem_waddr}, {28'd0, m_waddr});
    check("mem_wdata", {24'd0, mem_wdata}, {24'd0, m_wdata});
    check("cmd_err",   {31'd0, cmd_err},   {31'd0, m_err});
    check("bp_hit",    {31'd0, bp_hit},    {31'd0, m_bp});
    check("state",     {30'd0, state},     {30'd0, e_state});
    check("cycle_cnt", {16'd0, cycle_cnt}, (m_cnt > 65535) ? 32'd65535 : m_cnt);
    check("cycle_cnt4", {28'd0, cycle_cnt4}, (m_cnt > 15) ? 32'd15 : m_cnt);
    check("cpu_en4",   {31'd0, cpu_en4},   {31'd0, e_cpu});
    if (acc)
      $display("txn t=%0t op=%0d addr=%0h data=%02h state=%0d", $time, cmd_op, cmd_addr, cmd_data, e_state);
    if (reset) begin
      m_run = 0; m_step = 0; m_load = 0; m_first = 0; m_bp = 0; m_err = 0;
      m_waddr = 0; m_wdata = 0; m_cnt = 0;
    end else begin
      if (e_cpu) m_cnt++;
      m_err = 0;
      if (BP && acc && (cmd_op == 2'd0 || cmd_op == 2'd2)) m_bp = 0;
      if (m_step) m_step = 0;
      else if (m_load) m_load = 0;
      else if (m_run) begin
        if (acc && cmd_op == 2'd1) m_run = 0;
        if (acc && cmd_op[1]) m_err = 1;
        if (hit) begin m_run = 0; m_bp = 1; end
        m_first = 0;
      end else if (acc) begin
        case (cmd_op)
          2'd0: begin m_run = 1; m_first = 1; end
          2'd2: m_step = 1;
          2'd3: begin m_load = 1; m_waddr = cmd_addr; m_wdata = cmd_data; end
          default: ;
        endcase
      end
    end
  end

  // Present a command and hold it until accepted; returns just after the accept edge.
  task automatic send(input logic [1:0] op, input logic [3:0] a, input logic [7:0] d);
    int n;
    @(posedge clock); #1;
    cmd_valid = 1'b1; cmd_op = op; cmd_addr = a; cmd_data = d;
    n = 0;
    @(negedge clock);
    while (!cmd_ready && n < 20) begin @(negedge clock); n++; end
    check("accept_timeout", {31'd0, cmd_ready}, 32'd1);
    @(posedge clock); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clock); #1; reset = 1'b1;
    @(posedge clock); #1; reset = 1'b0;
  endtask

  initial begin
    int n;
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    // Reset state
    @(negedge clock);
    check("rst_ready", {31'd0, cmd_ready}, 32'd0);
    check("rst_state", {30'd0, state}, 32'd0);
    check("rst_cnt", {16'd0, cycle_cnt}, 32'd0);
    @(posedge clock); #1; reset = 1'b0;

    // 1: LOAD
    send(2'd3, 4'd3, 8'h5A);
    @(negedge clock);
    check("load_we", {31'd0, mem_we}, 32'd1);
    check("load_waddr", {28'd0, mem_waddr}, 32'd3);
    check("load_wdata", {24'd0, mem_wdata}, 32'h5A);
    check("load_cpu_en", {31'd0, cpu_en}, 32'd0);
    @(negedge clock);
    check("load_done_state", {30'd0, state}, 32'd0);
    check("load_done_ready", {31'd0, cmd_ready}, 32'd1);

    // 2: STEP
    send(2'd2, 4'd0, 8'd0);
    @(negedge clock);
    check("step_cpu_en", {31'd0, cpu_en}, 32'd1);
    @(negedge clock);
    check("step_after_en", {31'd0, cpu_en}, 32'd0);
    check("step_cnt", {16'd0, cycle_cnt}, 32'd1);
    check("step_state", {30'd0, state}, 32'd0);

    // 3: RUN for 10 cycles
    send(2'd0, 4'd0, 8'd0);
    repeat (8) @(posedge clock);
    send(2'd1, 4'd0, 8'd0);
    @(negedge clock);
    check("run10_cnt", {16'd0, cycle_cnt}, 32'd11);
    check("run10_state", {30'd0, state}, 32'd0);

    // 4: STEP while running
    send(2'd0, 4'd0, 8'd0);
    send(2'd2, 4'd0, 8'd0);
    @(negedge clock);
    check("err_pulse", {31'd0, cmd_err}, 32'd1);
    check("err_state", {30'd0, state}, 32'd1);
    check("err_cpu_en", {31'd0, cpu_en}, 32'd1);
    @(negedge clock);
    check("err_clear", {31'd0, cmd_err}, 32'd0);
    send(2'd1, 4'd0, 8'd0);

    // 5: breakpoint at address 5
    do_reset();
    bp_en = 1'b1; bp_addr = 4'd5;
    send(2'd0, 4'd0, 8'd0);
    if (BP) begin
      n = 0;
      @(negedge clock);
      while (state != 2'd0 && n < 40) begin @(negedge clock); n++; end
      check("bp_halted", {30'd0, state}, 32'd0);
      check("bp_flag", {31'd0, bp_hit}, 32'd1);
      check("bp_fetch", {28'd0, fetch_addr}, 32'd5);
      check("bp_cnt", {16'd0, cycle_cnt}, 32'd5);
      send(2'd0, 4'd0, 8'd0);
      @(negedge clock);
      check("bp_resume_en", {31'd0, cpu_en}, 32'd1);
      check("bp_resume_flag", {31'd0, bp_hit}, 32'd0);
    end else begin
      repeat (10) @(negedge clock);
      check("nobp_running", {30'd0, state}, 32'd1);
      check("nobp_past5", {31'd0, (fetch_addr > 4'd5)}, 32'd1);
      check("nobp_flag", {31'd0, bp_hit}, 32'd0);
    end
    bp_en = 1'b0;
    send(2'd1, 4'd0, 8'd0);

    // 6: reset during LOAD
    send(2'd3, 4'd9, 8'hC3);
    reset = 1'b1;
    @(negedge clock);
    check("rstload_we", {31'd0, mem_we}, 32'd0);
    @(posedge clock); #1; reset = 1'b0;
    @(negedge clock);
    check("rstload_state", {30'd0, state}, 32'd0);

    // Saturation of the narrow counter
    send(2'd0, 4'd0, 8'd0);
    repeat (18) @(posedge clock);
    send(2'd1, 4'd0, 8'd0);
    @(negedge clock);
    check("sat_cnt4", {28'd0, cycle_cnt4}, 32'd15);
    check("sat_cnt16", {16'd0, cycle_cnt}, 32'd20);

    // Random phase
    for (int i = 0; i < 1500; i++) begin
      @(posedge clock); #1;
      reset     = ($urandom_range(0, 99) == 0);
      cmd_valid = ($urandom_range(0, 2) == 0);
      cmd_op    = 2'($urandom_range(0, 3));
      cmd_addr  = 4'($urandom);
      cmd_data  = 8'($urandom);
      bp_en     = ($urandom_range(0, 1) == 1);
      bp_addr   = 4'($urandom);
    end
    @(posedge clock); #1;
    reset = 1'b0; cmd_valid = 1'b0;
    @(negedge clock);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
